// File: rtl/expr_eval.sv
`default_nettype none
//============================================================================
// Module      : expr_eval
// Description : Streaming evaluator for "number (op number)* '='" expressions
//               with '+' and '*' ('*' binds tighter), one character per cycle.
// Revision    : 1.0 - initial release
//============================================================================
module expr_eval #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic [W-1:0] result,
    output logic         done,
    output logic         err,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_NUM    = 2'd1,
        S_OPWAIT = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [7:0] C_CH_0   = 8'h30;
    localparam logic [7:0] C_CH_9   = 8'h39;
    localparam logic [7:0] C_CH_ADD = 8'h2B;
    localparam logic [7:0] C_CH_MUL = 8'h2A;
    localparam logic [7:0] C_CH_EQ  = 8'h3D;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_sum, r_prod, r_num;
    logic         r_pend_mul;

    logic [W-1:0] w_sum_nxt, w_prod_nxt, w_num_nxt, w_result_nxt;
    logic         w_pend_mul_nxt, w_done_nxt, w_err_nxt;

    logic         w_is_digit;
    logic [W-1:0] w_digit, w_num_acc, w_mul, w_term, w_sum_term;

    assign w_is_digit = (in >= C_CH_0) && (in <= C_CH_9);
    assign w_digit    = {{(W-4){1'b0}}, in[3:0]};
    // num*10 as shift-add keeps the accumulate step single-cycle and width-exact
    assign w_num_acc  = (r_num << 3) + (r_num << 1) + w_digit;
    assign w_mul      = r_prod * r_num;
    assign w_term     = r_pend_mul ? w_mul : r_num;
    assign w_sum_term = r_sum + w_term;

    assign busy = (r_state != S_START);

    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_prod_nxt     = r_prod;
        w_num_nxt      = r_num;
        w_pend_mul_nxt = r_pend_mul;
        w_result_nxt   = result;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;

        if (in_valid) begin
            case (r_state)
                S_START: begin
                    if (w_is_digit) begin
                        w_num_nxt   = w_digit;
                        w_state_nxt = S_NUM;
                    end else if (in == C_CH_EQ) begin
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
                S_NUM: begin
                    if (w_is_digit) begin
                        w_num_nxt = w_num_acc;
                    end else if (in == C_CH_MUL) begin
                        w_prod_nxt     = w_term;
                        w_pend_mul_nxt = 1'b1;
                        w_state_nxt    = S_OPWAIT;
                    end else if (in == C_CH_ADD) begin
                        w_sum_nxt      = w_sum_term;
                        w_pend_mul_nxt = 1'b0;
                        w_state_nxt    = S_OPWAIT;
                    end else if (in == C_CH_EQ) begin
                        w_result_nxt   = w_sum_term;
                        w_done_nxt     = 1'b1;
                        w_sum_nxt      = '0;
                        w_prod_nxt     = '0;
                        w_num_nxt      = '0;
                        w_pend_mul_nxt = 1'b0;
                        w_state_nxt    = S_START;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
                S_OPWAIT: begin
                    if (w_is_digit) begin
                        w_num_nxt   = w_digit;
                        w_state_nxt = S_NUM;
                    end else if (in == C_CH_EQ) begin
                        w_err_nxt      = 1'b1;
                        w_sum_nxt      = '0;
                        w_prod_nxt     = '0;
                        w_num_nxt      = '0;
                        w_pend_mul_nxt = 1'b0;
                        w_state_nxt    = S_START;
                    end else begin
                        w_state_nxt = S_ERR;
                    end
                end
                default: begin
                    if (in == C_CH_EQ) begin
                        w_err_nxt      = 1'b1;
                        w_sum_nxt      = '0;
                        w_prod_nxt     = '0;
                        w_num_nxt      = '0;
                        w_pend_mul_nxt = 1'b0;
                        w_state_nxt    = S_START;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_START;
            r_sum      <= '0;
            r_prod     <= '0;
            r_num      <= '0;
            r_pend_mul <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sum      <= w_sum_nxt;
            r_prod     <= w_prod_nxt;
            r_num      <= w_num_nxt;
            r_pend_mul <= w_pend_mul_nxt;
            result     <= w_result_nxt;
            done       <= w_done_nxt;
            err        <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_expr_eval.sv
`default_nettype none
//============================================================================
// Module      : tb_expr_eval
// Description : Scoreboard bench for expr_eval driven by directed strings.
// Revision    : 1.0 - initial release
//============================================================================
module tb_expr_eval;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr_n = 1'b0;
    logic [7:0]   in = 8'h00;
    logic         in_valid = 1'b0;
    logic [W-1:0] result;
    logic         done, err, busy;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] res;
    } exp_t;

    exp_t         sb[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    logic [W-1:0] model_result = '0;

    expr_eval #(.W(W)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .in       (in),
        .in_valid (in_valid),
        .result   (result),
        .done     (done),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clr_n && (done || err)) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b result=%0d, expected no pulse", done, err, result);
            end else begin
                e = sb.pop_front();
                check("both_pulses", W'(done && err), W'(0));
                check("pulse_kind_err", W'(err), W'(e.is_err));
                check("result", result, e.res);
            end
        end
    end

    task automatic expect_done(input logic [W-1:0] v);
        exp_t e;
        e.is_err = 1'b0;
        e.res = v;
        model_result = v;
        sb.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.res = model_result;
        sb.push_back(e);
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk);
            #1;
            in = s[i];
            in_valid = 1'b1;
            if (max_gap > 0) begin
                int k;
                k = $urandom_range(max_gap, 1);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in = 8'($urandom_range(255, 0));
                repeat (k - 1) @(posedge clk);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", W'(sb.size()), W'(0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset_result", result, '0);
        check("reset_done", W'(done), '0);
        check("reset_err", W'(err), '0);
        check("reset_busy", W'(busy), '0);
        clr_n = 1'b1;

        expect_done(32'd24);
        send_str("12+3*4=", 0);
        expect_done(32'd29);
        send_str("2*3*4+5=", 0);
        expect_done(32'd7);
        send_str("7=", 0);
        expect_done(32'd68);
        send_str("2+3*4*5+6=", 0);

        // malformed expressions keep the previous result and recover
        expect_err();
        send_str("3+=", 0);
        expect_err();
        send_str("3a4=", 0);
        expect_done(32'd8);
        send_str("8=", 0);
        expect_err();
        send_str("=", 0);

        expect_done(32'd0);
        send_str("65536*65536=", 0);
        expect_done(32'd4294967295);
        send_str("4294967295=", 0);
        wait_drain();

        // busy rises once an expression is under way
        @(posedge clk);
        #1;
        in = "9";
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in = "9";
        @(negedge clk);
        check("busy_mid_expr", W'(busy), W'(1));
        @(posedge clk);
        #1;
        in = "+";
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check("mid_reset_result", result, '0);
        check("mid_reset_busy", W'(busy), '0);
        check("mid_reset_done", W'(done), '0);
        model_result = '0;
        @(negedge clk);
        #1;
        clr_n = 1'b1;
        expect_done(32'd5);
        send_str("5=", 0);

        expect_done(32'd3);
        send_str("1+2=", 4);
        wait_drain();
        repeat (5) @(negedge clk);
        check("result_holds", result, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/expr_eval.md
EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 Parameter W, default 32, width of the accumulators and of result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr_n  input  1  reset, asynchronous, active-low.
REQ-004 in  input  8  ASCII character from the upstream character stream.
REQ-005 in_valid  input  1  the character on in is consumed on this edge only when in_valid=1.
REQ-006 result  output  W  value of the last correctly terminated expression.
REQ-007 done  output  1  one-cycle pulse: result was updated.
REQ-008 err  output  1  one-cycle pulse: the terminated expression was malformed.
REQ-009 busy  output  1  high while an expression is partially consumed, that is, in any state other than START.

Function
REQ-010 Grammar: expression = number (op number)* '='.
- number: one or more '0'-'9'.
- op: '+' or '*'.
- '*' binds tighter than '+'.
- Evaluation is left to right within each precedence level.
REQ-011 The block holds the following internal registers:
- sum (W bits)
- prod (W bits)
- num (W bits)
- pend_mul (1 bit)
- state: START, NUM, OPWAIT, ERR.
REQ-012 A cycle with in_valid=0 changes no register, and done and err are 0 in that cycle.
REQ-013 term is defined as (pend_mul ? prod*num : num), truncated to W bits.
REQ-014 START handling:
- digit d: num<=d, go to NUM.
- any other character, including '=': go to ERR, except that '=' alone is handled by REQ-018.
REQ-015 NUM handling:
- digit d: num<=num*10+d, truncated to W bits.
- '*': prod<=term, pend_mul<=1, go to OPWAIT.
- '+': sum<=sum+term, pend_mul<=0, go to OPWAIT.
- '=': result<=sum+term, done<=1, clear sum, prod, num and pend_mul, go to START.
- any other character: go to ERR.
REQ-016 OPWAIT handling:
- digit d: num<=d, go to NUM.
- '=': err<=1, clear the accumulators, go to START.
- any other character: go to ERR.
REQ-017 ERR handling:
- '=': err<=1, clear the accumulators, go to START.
- any other character: ignored, stay in ERR.
REQ-018 '=' received in START pulses err, leaves result unchanged and stays in START.
REQ-019 Latency: done or err is asserted in the cycle immediately after the edge that consumed '='. result changes on that same edge and holds until the next done.
REQ-020 done and err are never high in the same cycle.
REQ-021 result is never modified by an err termination.
REQ-022 All arithmetic is unsigned modulo 2^W; overflow is silent and is not an error.
REQ-023 Multiplication by 10 and by prod shall complete in one cycle, so that back-to-back characters with in_valid=1 every cycle are accepted with no stall.
REQ-024 There is no backpressure; the block always accepts a character when in_valid=1.

Reset
REQ-025 While clr_n=0, independent of clk, the block is held in reset:
- state=START
- sum=0, prod=0, num=0, pend_mul=0
- result=0
- done=0, err=0, busy=0
REQ-026 Reset asserted mid-expression discards all partial state. The first digit after clr_n rises starts a new expression.
REQ-027 The first clock edge after clr_n deasserts shall be processed normally.

Verification
REQ-028 Stream "12+3*4=", one character per cycle -> done pulse, result=24, err never asserted.
REQ-029 Stream "2*3*4+5=" followed by "7=" -> first done gives result=29, second done gives result=7.
REQ-030 Stream "3+=" -> err pulse, result keeps its previous value. Stream "3a4=" -> err pulse on '=', and the block recovers for the next expression.
REQ-031 With W=32, stream "65536*65536=" -> done, result=0 (wrap-around).
REQ-032 Send "99+" and pulse clr_n low between clock edges, then send "5=" -> result goes to 0 during reset, then done with result=5, and busy=0 during reset.
REQ-033 Stream "1+2=" with in_valid=0 gaps of random length between characters -> result=3 and done asserted exactly once.
